reg_file_sched: RTL and testbench

- Round-robin scheduler that shares the 8x8 dual-write/single-read register file among NREQ requesters.
- Each cycle it issues either one read or up to two writes. It drives the register file's command inputs (rw1w2, write/read addresses, write data).
- Routes the registered read data back to the requester that issued the read.
- Sits between client blocks and the register file; it is the only master of the register file.

---
 rtl/reg_file_sched.sv | 128 ++++++++++++
 tb/tb_reg_file_sched.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sched.sv
// Round-robin scheduler issuing one read or up to two writes per cycle to an 8x8 register file.
// Macro RFSCHED_DUAL_WRITE_EN enables pairing a second, different-address write on port 2.
module reg_file_sched #(
   parameter int NREQ = 4,
   parameter int AW   = 3,
   parameter int DW   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    req_we,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_wdata,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    rsp_valid,
   output logic [DW-1:0]      rsp_data,
   output logic [1:0]         rf_rw1w2,
   output logic [AW-1:0]      rf_write_add_1,
   output logic [AW-1:0]      rf_write_add_2,
   output logic [AW-1:0]      rf_read_add,
   output logic [DW-1:0]      rf_write_data_1,
   output logic [DW-1:0]      rf_write_data_2,
   input  logic [DW-1:0]      rf_read_data
);
   localparam int PW = $clog2(NREQ);

   logic [PW-1:0]   r_ptr;
   logic [NREQ-1:0] r_rsp_valid;

   logic [PW-1:0]   w_idx   [NREQ];
   logic [AW-1:0]   w_addr  [NREQ];
   logic [DW-1:0]   w_wdata [NREQ];

   // w_idx[k] is the client visited k steps after the pointer in scan order
   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_client
         logic [PW:0] w_sum;
         assign w_sum        = {1'b0, r_ptr} + (PW+1)'(gi);
         assign w_idx[gi]    = (w_sum >= (PW+1)'(NREQ)) ? PW'(w_sum - (PW+1)'(NREQ)) : w_sum[PW-1:0];
         assign w_addr[gi]   = req_addr[gi*AW +: AW];
         assign w_wdata[gi]  = req_wdata[gi*DW +: DW];
      end
   endgenerate

   logic            w_p_found;
   logic [PW-1:0]   w_p_off;
   logic [PW-1:0]   w_p;
   logic [PW-1:0]   w_last;
   logic [PW-1:0]   w_next_ptr;
   logic [NREQ-1:0] w_rd_gnt;
`ifdef RFSCHED_DUAL_WRITE_EN
   logic            w_s_found;
   logic [PW-1:0]   w_s;
`endif

   always_comb begin
      w_p_found = 1'b0;
      w_p_off   = '0;
      for (int k = NREQ-1; k >= 0; k--) begin
         if (req[w_idx[k]]) begin
            w_p_found = 1'b1;
            w_p_off   = PW'(k);
         end
      end
      w_p = w_idx[w_p_off];

`ifdef RFSCHED_DUAL_WRITE_EN
      // Partner must be a later write to a different address, so no write is ever lost
      w_s_found = 1'b0;
      w_s       = '0;
      for (int k = NREQ-1; k >= 1; k--) begin
         if ((k > int'(w_p_off)) && req[w_idx[k]] && req_we[w_idx[k]] &&
             (w_addr[w_idx[k]] != w_addr[w_p])) begin
            w_s_found = 1'b1;
            w_s       = w_idx[k];
         end
      end
`endif

      gnt             = '0;
      rf_rw1w2        = 2'd0;
      rf_read_add     = '0;
      rf_write_add_1  = '0;
      rf_write_data_1 = '0;
      rf_write_add_2  = '0;
      rf_write_data_2 = '0;
      w_rd_gnt        = '0;
      w_last          = w_p;
      w_next_ptr      = r_ptr;

      if (rst && w_p_found) begin
         gnt[w_p] = 1'b1;
         if (!req_we[w_p]) begin
            rf_read_add    = w_addr[w_p];
            w_rd_gnt[w_p]  = 1'b1;
         end else begin
            rf_rw1w2        = 2'd1;
            rf_write_add_1  = w_addr[w_p];
            rf_write_data_1 = w_wdata[w_p];
`ifdef RFSCHED_DUAL_WRITE_EN
            if (w_s_found) begin
               gnt[w_s]        = 1'b1;
               rf_rw1w2        = 2'd3;
               rf_write_add_2  = w_addr[w_s];
               rf_write_data_2 = w_wdata[w_s];
               w_last          = w_s;
            end
`endif
         end
         w_next_ptr = (w_last == PW'(NREQ-1)) ? '0 : w_last + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_ptr       <= '0;
         r_rsp_valid <= '0;
      end else begin
         r_ptr       <= w_next_ptr;
         r_rsp_valid <= w_rd_gnt;
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = rf_read_data;

endmodule

// File: tb/tb_reg_file_sched.sv
// Testbench for reg_file_sched: directed vector table, reset corner sequence, randomized model check.
// Expectations follow RFSCHED_DUAL_WRITE_EN when the macro is defined for the build.
module tb_reg_file_sched;
   localparam int N  = 4;
   localparam int AW = 3;
   localparam int DW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst;
   logic [N-1:0]    req, req_we;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [N-1:0]    gnt, rsp_valid;
   logic [DW-1:0]   rsp_data;
   logic [1:0]      rf_rw1w2;
   logic [AW-1:0]   rf_write_add_1, rf_write_add_2, rf_read_add;
   logic [DW-1:0]   rf_write_data_1, rf_write_data_2, rf_read_data;

   reg_file_sched #(.NREQ(N), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .rf_rw1w2(rf_rw1w2), .rf_write_add_1(rf_write_add_1), .rf_write_add_2(rf_write_add_2),
      .rf_read_add(rf_read_add), .rf_write_data_1(rf_write_data_1),
      .rf_write_data_2(rf_write_data_2), .rf_read_data(rf_read_data)
   );

   // Register file: two write ports, registered read
   logic          tb_clear;
   logic [DW-1:0] rf_mem [8];
   always @(posedge clk) begin
      if (tb_clear) begin
         for (int i = 0; i < 8; i++) rf_mem[i] <= '0;
         rf_read_data <= '0;
      end else begin
         if (rf_rw1w2[0]) rf_mem[rf_write_add_1] <= rf_write_data_1;
         if (rf_rw1w2[1]) rf_mem[rf_write_add_2] <= rf_write_data_2;
         if (rf_rw1w2 == 2'd0) rf_read_data <= rf_mem[rf_read_add];
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        rst;
      logic [3:0]  req;
      logic [3:0]  we;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [3:0]  egnt;
      logic [1:0]  erw;
      logic [3:0]  ersp;
      logic [7:0]  edata;
   } vec_t;

   vec_t tbl[$];
   vec_t v;

   function automatic logic [11:0] pa(input int a0, input int a1, input int a2, input int a3);
      return {3'(a3), 3'(a2), 3'(a1), 3'(a0)};
   endfunction

   function automatic logic [31:0] pd(input int d0, input int d1, input int d2, input int d3);
      return {8'(d3), 8'(d2), 8'(d1), 8'(d0)};
   endfunction

   task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] we,
                      input logic [11:0] ad, input logic [31:0] wd, input logic [3:0] eg,
                      input logic [1:0] erw, input logic [3:0] ers, input logic [7:0] ed);
      vec_t t;
      t.rst = r; t.req = rq; t.we = we; t.addr = ad; t.wdata = wd;
      t.egnt = eg; t.erw = erw; t.ersp = ers; t.edata = ed;
      tbl.push_back(t);
   endtask

   task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] we,
                        input logic [11:0] ad, input logic [31:0] wd);
      rst = r; req = rq; req_we = we; req_addr = ad; req_wdata = wd;
   endtask

   // Reference model state for the random phase
   bit            pend [N];
   bit            pwe  [N];
   logic [2:0]    pad  [N];
   logic [7:0]    pdt  [N];
   logic [7:0]    shadow [8];
   int            mptr, p, s, pk, c, last, exp_rc;
   logic [7:0]    exp_rd;
   logic [3:0]    e_gnt, e_rsp;
   logic [1:0]    e_rw;

   initial begin
      tb_clear = 1'b1;
      drive(1'b0, '0, '0, '0, '0);

      // reset, first grant, dual write, conflict, exclusivity, fairness
      for (int i = 0; i < 3; i++) add(0, 4'b1111, 4'b0000, pa(0,0,0,0), 0, 4'b0000, 0, 4'b0000, 0);
      add(1, 4'b1111, 4'b0000, pa(0,0,0,0), 0, 4'b0001, 0, 4'b0000, 0);
      add(1, 4'b1000, 4'b0000, pa(0,0,0,0), 0, 4'b1000, 0, 4'b0001, 8'h00);
`ifdef RFSCHED_DUAL_WRITE_EN
      add(1, 4'b0101, 4'b0101, pa(1,0,4,0), pd(8'hA5,0,8'h3C,0), 4'b0101, 3, 4'b1000, 8'h00);
`else
      add(1, 4'b0101, 4'b0101, pa(1,0,4,0), pd(8'hA5,0,8'h3C,0), 4'b0001, 1, 4'b1000, 8'h00);
      add(1, 4'b0100, 4'b0100, pa(0,0,4,0), pd(0,0,8'h3C,0), 4'b0100, 1, 4'b0000, 0);
`endif
      add(1, 4'b0010, 4'b0000, pa(0,4,0,0), 0, 4'b0010, 0, 4'b0000, 0);
      add(1, 4'b0011, 4'b0011, pa(5,5,0,0), pd(8'h11,8'h22,0,0), 4'b0001, 1, 4'b0010, 8'h3C);
      add(1, 4'b0010, 4'b0010, pa(0,5,0,0), pd(0,8'h22,0,0), 4'b0010, 1, 4'b0000, 0);
      add(1, 4'b1000, 4'b0000, pa(0,0,0,5), 0, 4'b1000, 0, 4'b0000, 0);
      add(1, 4'b0011, 4'b0010, pa(2,6,0,0), pd(0,8'h77,0,0), 4'b0001, 0, 4'b1000, 8'h22);
      add(1, 4'b0010, 4'b0010, pa(0,6,0,0), pd(0,8'h77,0,0), 4'b0010, 1, 4'b0001, 8'h00);
      add(1, 4'b1000, 4'b0000, pa(0,0,0,6), 0, 4'b1000, 0, 4'b0000, 0);
      add(1, 4'b1111, 4'b0000, pa(1,4,5,6), 0, 4'b0001, 0, 4'b1000, 8'h77);
      add(1, 4'b1111, 4'b0000, pa(1,4,5,6), 0, 4'b0010, 0, 4'b0001, 8'hA5);
      add(1, 4'b1111, 4'b0000, pa(1,4,5,6), 0, 4'b0100, 0, 4'b0010, 8'h3C);
      add(1, 4'b1111, 4'b0000, pa(1,4,5,6), 0, 4'b1000, 0, 4'b0100, 8'h22);
      add(1, 4'b1111, 4'b0000, pa(1,4,5,6), 0, 4'b0001, 0, 4'b1000, 8'h77);
      add(1, 4'b1111, 4'b0000, pa(1,4,5,6), 0, 4'b0010, 0, 4'b0001, 8'hA5);
      add(1, 4'b1111, 4'b0000, pa(1,4,5,6), 0, 4'b0100, 0, 4'b0010, 8'h3C);
      add(1, 4'b1111, 4'b0000, pa(1,4,5,6), 0, 4'b1000, 0, 4'b0100, 8'h22);
      add(1, 4'b0000, 4'b0000, pa(1,4,5,6), 0, 4'b0000, 0, 4'b1000, 8'h77);

      for (int i = 0; i < tbl.size(); i++) begin
         v = tbl[i];
         @(negedge clk);
         tb_clear = (i < 3);
         drive(v.rst, v.req, v.we, v.addr, v.wdata);
         #1;
         chk($sformatf("row%0d gnt", i), gnt, v.egnt);
         chk($sformatf("row%0d rw1w2", i), rf_rw1w2, v.erw);
         chk($sformatf("row%0d rsp_valid", i), rsp_valid, v.ersp);
         if (v.ersp != 0) chk($sformatf("row%0d rsp_data", i), rsp_data, v.edata);
         if (!v.rst)
            chk($sformatf("row%0d rf_out_in_reset", i),
                {rf_read_add, rf_write_add_1, rf_write_add_2, rf_write_data_1, rf_write_data_2}, 0);
         $display("row %0d rst=%b req=%b we=%b gnt=%b rw=%0d rsp=%b data=%h",
                  i, v.rst, v.req, v.we, gnt, rf_rw1w2, rsp_valid, rsp_data);
      end

      // Reset mid-operation: pending response dropped, write at reset edge not issued
      @(negedge clk); drive(1, 4'b0001, 4'b0000, pa(1,0,0,0), 0); #1;
      chk("mid_a gnt", gnt, 4'b0001);
      @(negedge clk); drive(0, 4'b0011, 4'b0011, pa(1,4,0,0), pd(8'hFF,8'hEE,0,0)); #1;
      chk("mid_b gnt", gnt, 4'b0000);
      chk("mid_b rw1w2", rf_rw1w2, 2'd0);
      chk("mid_b rsp_valid", rsp_valid, 4'b0001);
      chk("mid_b rsp_data", rsp_data, 8'hA5);
      @(negedge clk); drive(1, 4'b1111, 4'b0000, pa(1,4,5,6), 0); #1;
      chk("mid_c rsp_valid", rsp_valid, 4'b0000);
      chk("mid_c gnt", gnt, 4'b0001);
      @(negedge clk); drive(1, 4'b0000, 4'b0000, pa(0,0,0,0), 0); #1;
      chk("mid_d rsp_valid", rsp_valid, 4'b0001);
      chk("mid_d rsp_data", rsp_data, 8'hA5);
      $display("reset mid-operation sequence done");

      // Random phase: reset, preload every address, then random held requests
      @(negedge clk); drive(0, '0, '0, '0, '0);
      @(negedge clk); drive(0, '0, '0, '0, '0);
      for (int a = 0; a < 8; a++) begin
         shadow[a] = 8'($urandom);
         @(negedge clk);
         drive(1, 4'b0001, 4'b0001, pa(a,0,0,0), pd(shadow[a],0,0,0));
         #1;
         chk($sformatf("pre%0d gnt", a), gnt, 4'b0001);
         chk($sformatf("pre%0d rw1w2", a), rf_rw1w2, 2'd1);
         chk($sformatf("pre%0d port1", a), {rf_write_add_1, rf_write_data_1}, {3'(a), shadow[a]});
         $display("preload addr %0d data %h", a, shadow[a]);
      end
      mptr = 1;
      exp_rc = -1;
      exp_rd = '0;
      for (int i = 0; i < N; i++) pend[i] = 0;

      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
               pend[i] = 1;
               pwe[i]  = ($urandom_range(0, 1) == 1);
               pad[i]  = 3'($urandom_range(0, 3));
               pdt[i]  = 8'($urandom);
            end
         end
         @(negedge clk);
         rst = 1'b1;
         for (int i = 0; i < N; i++) begin
            req[i]              = pend[i];
            req_we[i]           = pwe[i];
            req_addr[i*AW +: AW] = pad[i];
            req_wdata[i*DW +: DW] = pdt[i];
         end
         #1;

         p = -1; s = -1; pk = 0;
         for (int k = 0; k < N; k++) begin
            c = (mptr + k) % N;
            if (pend[c]) begin p = c; pk = k; break; end
         end
`ifdef RFSCHED_DUAL_WRITE_EN
         if (p >= 0 && pwe[p]) begin
            for (int k = pk + 1; k < N; k++) begin
               c = (mptr + k) % N;
               if (pend[c] && pwe[c] && pad[c] != pad[p]) begin s = c; break; end
            end
         end
`endif
         e_gnt = '0;
         if (p >= 0) e_gnt[p] = 1'b1;
         if (s >= 0) e_gnt[s] = 1'b1;
         e_rw = (p < 0 || !pwe[p]) ? 2'd0 : (s >= 0 ? 2'd3 : 2'd1);
         e_rsp = '0;
         if (exp_rc >= 0) e_rsp[exp_rc] = 1'b1;

         chk($sformatf("rnd%0d gnt", cyc), gnt, e_gnt);
         chk($sformatf("rnd%0d rw1w2", cyc), rf_rw1w2, e_rw);
         chk($sformatf("rnd%0d rsp_valid", cyc), rsp_valid, e_rsp);
         if (exp_rc >= 0) chk($sformatf("rnd%0d rsp_data", cyc), rsp_data, exp_rd);
         if (p < 0) chk($sformatf("rnd%0d idle_read_add", cyc), rf_read_add, 0);
         else if (!pwe[p]) chk($sformatf("rnd%0d read_add", cyc), rf_read_add, pad[p]);
         else chk($sformatf("rnd%0d port1", cyc), {rf_write_add_1, rf_write_data_1}, {pad[p], pdt[p]});
         if (s >= 0) chk($sformatf("rnd%0d port2", cyc), {rf_write_add_2, rf_write_data_2}, {pad[s], pdt[s]});
`ifndef RFSCHED_DUAL_WRITE_EN
         chk($sformatf("rnd%0d port2_zero", cyc), {rf_write_add_2, rf_write_data_2}, 0);
`endif
         $display("rnd %0d req=%b we=%b gnt=%b rw=%0d rsp=%b", cyc, req, req_we, gnt, rf_rw1w2, rsp_valid);

         exp_rc = -1;
         if (p >= 0) begin
            if (!pwe[p]) begin
               exp_rc = p;
               exp_rd = shadow[pad[p]];
            end else begin
               shadow[pad[p]] = pdt[p];
               if (s >= 0) shadow[pad[s]] = pdt[s];
            end
            last = (s >= 0) ? s : p;
            mptr = (last + 1) % N;
            pend[p] = 0;
            if (s >= 0) pend[s] = 0;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
